// File: rtl/demux8_rr_scheduler.sv
// Round-robin scheduler feeding a 1:8 demux: each accepted beat is buffered
// in a single slot and offered to the next enabled channel in rotating order.
module demux8_rr_scheduler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [7:0]       ch_en,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       sel,
  output logic [15:0]      tx_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [2:0]       ptr_q;
  logic [2:0]       sel_q;
  logic [7:0]       out_valid_q;
  logic [WIDTH-1:0] data_q;
  logic [15:0]      tx_count_q;

  logic       xfer;
  logic       acc;
  logic       en_any;
  logic [2:0] base;
  logic [2:0] target_d;
  logic [2:0] idx;
  logic       found;

  assign xfer     = (state_q == FULL) && out_ready[sel_q];
  assign en_any   = |ch_en;
  assign base     = xfer ? (sel_q + 3'd1) : ptr_q;
  assign in_ready = en_any && ((state_q == EMPTY) || xfer);
  assign acc      = in_valid && in_ready;

  // First enabled channel at or after base, wrapping modulo 8.
  always_comb begin
    target_d = base;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = base + 3'(k);
      if (!found && ch_en[idx]) begin
        target_d = idx;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      ptr_q       <= '0;
      sel_q       <= '0;
      out_valid_q <= '0;
      data_q      <= '0;
      tx_count_q  <= '0;
    end else begin
      if (xfer) begin
        ptr_q      <= sel_q + 3'd1;
        tx_count_q <= tx_count_q + 16'd1;
      end
      // A same-cycle accept overrides the drain, keeping the slot FULL.
      if (acc) begin
        state_q     <= FULL;
        data_q      <= in_data;
        sel_q       <= target_d;
        out_valid_q <= 8'b1 << target_d;
      end else if (xfer) begin
        state_q     <= EMPTY;
        out_valid_q <= '0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_demux8_rr_scheduler.sv
// Directed bench for demux8_rr_scheduler with hand-computed expectations.
module tb_demux8_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [7:0]  ch_en = '0;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
  logic [7:0]  out_data;
  logic [2:0]  sel;
  logic [15:0] tx_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux8_rr_scheduler #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ch_en     (ch_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .tx_count  (tx_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ov", 32'(out_valid), 32'h00);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_tx", 32'(tx_count), 32'h0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_inrdy", 32'(in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full-rate rotation over all 8 channels
    ch_en = 8'hFF;
    out_ready = 8'hFF;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h10 + 8'(i);
      #1;
      chk("t1_inrdy", 32'(in_ready), 32'h1);
      tick();
      chk("t1_ov", 32'(out_valid), 32'h1 << i);
      chk("t1_sel", 32'(sel), 32'(i));
      chk("t1_data", 32'(out_data), 32'h10 + 32'(i));
      chk("t1_tx", 32'(tx_count), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("t1_ov_end", 32'(out_valid), 32'h00);
    chk("t1_tx_end", 32'(tx_count), 32'd8);

    // Sparse mask 1010_0100: channels 2,5,7 repeating
    ch_en = 8'b1010_0100;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'h20 + 8'(i);
      tick();
      chk("t2_sel", 32'(sel), (i % 3 == 0) ? 32'd2 : (i % 3 == 1) ? 32'd5 : 32'd7);
      chk("t2_data", 32'(out_data), 32'h20 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("t2_tx", 32'(tx_count), 32'd14);

    // Stall on ch0, then simultaneous drain and accept
    ch_en = 8'hFF;
    out_ready = 8'hFE;
    in_valid = 1'b1;
    in_data = 8'h30;
    tick();
    chk("t3_sel0", 32'(sel), 32'd0);
    in_data = 8'h31;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_inrdy", 32'(in_ready), 32'h0);
      tick();
      chk("t3_stall_ov", 32'(out_valid), 32'h01);
      chk("t3_stall_data", 32'(out_data), 32'h30);
    end
    out_ready = 8'hFF;
    #1;
    chk("t3_xa_inrdy", 32'(in_ready), 32'h1);
    tick();
    chk("t3_xa_ov", 32'(out_valid), 32'h02);
    chk("t3_xa_data", 32'(out_data), 32'h31);
    chk("t3_xa_tx", 32'(tx_count), 32'd15);
    in_valid = 1'b0;
    tick();
    chk("t3_tx", 32'(tx_count), 32'd16);

    // Held beat on ch3 survives ch_en[3] dropping; ch_en=0 blocks input
    ch_en = 8'h08;
    out_ready = 8'h00;
    in_valid = 1'b1;
    in_data = 8'h40;
    tick();
    chk("t4_ov3", 32'(out_valid), 32'h08);
    ch_en = 8'h00;
    in_data = 8'h41;
    #1;
    chk("t4_inrdy_off", 32'(in_ready), 32'h0);
    tick();
    chk("t4_hold_ov", 32'(out_valid), 32'h08);
    chk("t4_hold_data", 32'(out_data), 32'h40);
    out_ready = 8'h08;
    tick();
    chk("t4_deliv_ov", 32'(out_valid), 32'h00);
    chk("t4_deliv_tx", 32'(tx_count), 32'd17);
    chk("t4_deliv_sel", 32'(sel), 32'd3);
    #1;
    chk("t4_inrdy_idle", 32'(in_ready), 32'h0);
    tick();
    chk("t4_idle_ov", 32'(out_valid), 32'h00);

    // Asynchronous reset mid-cycle while holding on ch6
    ch_en = 8'h40;
    out_ready = 8'h00;
    in_data = 8'h50;
    tick();
    chk("t5_sel6", 32'(sel), 32'd6);
    chk("t5_ov6", 32'(out_valid), 32'h40);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ov", 32'(out_valid), 32'h00);
    chk("t5_rst_sel", 32'(sel), 32'd0);
    chk("t5_rst_tx", 32'(tx_count), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ch_en = 8'hFF;
    out_ready = 8'hFF;
    in_valid = 1'b1;
    in_data = 8'h60;
    #1;
    chk("t5_post_inrdy", 32'(in_ready), 32'h1);
    tick();
    chk("t5_post_sel", 32'(sel), 32'd0);
    chk("t5_post_ov", 32'(out_valid), 32'h01);
    in_valid = 1'b0;
    tick();
    chk("t5_post_tx", 32'(tx_count), 32'd1);

    // tx_count wrap: 65535 accepts at full rate deliver 65534 more beats
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 8'(i);
      tick();
    end
    chk("t6_tx_max", 32'(tx_count), 32'hFFFF);
    chk("t6_sel", 32'(sel), 32'd7);
    in_valid = 1'b0;
    tick();
    chk("t6_tx_wrap", 32'(tx_count), 32'h0000);
    chk("t6_ov", 32'(out_valid), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
